// File: rtl/irq_ctrl_pkg.sv
// Shared constants, types and helpers for the irq_ctrl_wb interrupt controller.
package irq_ctrl_pkg;

  localparam int DEF_NUM_SRC = 16;
  localparam int ID_W        = $clog2(DEF_NUM_SRC);

  localparam logic [7:0] OFS_PENDING  = 8'h00;
  localparam logic [7:0] OFS_ENABLE   = 8'h04;
  localparam logic [7:0] OFS_TRIGGER  = 8'h08;
  localparam logic [7:0] OFS_CLAIM    = 8'h0C;
  localparam logic [7:0] OFS_COMPLETE = 8'h10;

  localparam int CLAIM_BUSY_BIT = 31;
  localparam int CLAIM_ID_LSB   = 0;
  localparam int CLAIM_ID_W     = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } claim_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder; reports {valid, id}.
module irq_prio_enc #(
  parameter int N   = 16,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] id
);

  // Scan from the top so the lowest requesting index is the last one kept
  always_comb begin
    valid = 1'b0;
    id    = {IDW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      id    = req[i] ? IDW'(i) : id;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/irq_ctrl_wb.sv
// External interrupt controller with Wishbone classic configuration port.
// Optional build macro IRQ_CTRL_SYNC_EN adds a 2-flop input synchroniser.
module irq_ctrl_wb
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ADDR_W  = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               meip_o,
  input  logic               irq_ack_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [ADDR_W-1:0]  wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o
);

  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] src_s, src_prev_r, edge_s;
  logic [NUM_SRC-1:0] pending_r, enable_r, trigger_r;
  logic [NUM_SRC-1:0] pend_en_s, ack_clr_s, w1c_s, pending_nxt_s;
  logic [ADDR_W-1:0]  adr_s;
  logic [31:0]        wmask_s, wdata_m_s, rdata_s, claim_word_s, wb_dat_r;
  logic               access_s, wr_s, wr_pend_s, wr_en_s, wr_trig_s, complete_s;
  logic               wb_ack_r, meip_r, claim_s, win_valid_s;
  logic [IDW-1:0]     win_id_s, claim_id_r;
  claim_state_e       state_r, state_nxt_s;
  logic               unused_s;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_r, sync2_r;

  // Two-flop synchroniser for sources not clocked by clk_i
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_r <= {NUM_SRC{1'b0}};
      sync2_r <= {NUM_SRC{1'b0}};
    end else begin
      sync1_r <= irq_src_i;
      sync2_r <= sync1_r;
    end
  end
  assign src_s = sync2_r;
`else
  assign src_s = irq_src_i;
`endif

  assign access_s  = wb_cyc_i & wb_stb_i & ~wb_ack_r;
  assign wr_s      = access_s & wb_we_i;
  assign adr_s     = wb_adr_i & {{(ADDR_W - 2){1'b1}}, 2'b00};
  assign wmask_s   = byte_mask(wb_sel_i);
  assign wdata_m_s = wb_dat_i & wmask_s;
  assign unused_s  = ^{wmask_s, wdata_m_s};

  assign edge_s    = src_s & ~src_prev_r;
  assign pend_en_s = pending_r & enable_r;
  assign w1c_s     = wr_pend_s ? wdata_m_s[NUM_SRC-1:0] : {NUM_SRC{1'b0}};

  irq_prio_enc #(
    .N   (NUM_SRC),
    .IDW (IDW)
  ) u_prio (
    .req   (pend_en_s),
    .valid (win_valid_s),
    .id    (win_id_s)
  );

  // A late ack that lands while busy (even alongside COMPLETE) never claims
  assign claim_s   = (state_r == ST_IDLE) & irq_ack_i & win_valid_s;
  assign ack_clr_s = claim_s ? ((NUM_SRC'(1'b1) << win_id_s) & trigger_r) : {NUM_SRC{1'b0}};

  // Edge bits: set beats clear in the same cycle; level bits follow the source
  assign pending_nxt_s = (trigger_r & ((pending_r & ~(w1c_s | ack_clr_s)) | edge_s))
                       | (~trigger_r & src_s);

  // Register decode for reads and write strobes
  always_comb begin
    rdata_s    = 32'h0;
    wr_pend_s  = 1'b0;
    wr_en_s    = 1'b0;
    wr_trig_s  = 1'b0;
    complete_s = 1'b0;
    case (adr_s)
      ADDR_W'(OFS_PENDING): begin
        rdata_s   = 32'(pending_r);
        wr_pend_s = wr_s;
      end
      ADDR_W'(OFS_ENABLE): begin
        rdata_s = 32'(enable_r);
        wr_en_s = wr_s;
      end
      ADDR_W'(OFS_TRIGGER): begin
        rdata_s   = 32'(trigger_r);
        wr_trig_s = wr_s;
      end
      ADDR_W'(OFS_CLAIM):    rdata_s    = claim_word_s;
      ADDR_W'(OFS_COMPLETE): complete_s = wr_s;
      default:               rdata_s    = 32'h0;
    endcase
  end

  // CLAIM word: busy flag plus one-based source ID
  always_comb begin
    claim_word_s = 32'h0;
    if (state_r == ST_BUSY) begin
      claim_word_s[CLAIM_BUSY_BIT]                = 1'b1;
      claim_word_s[CLAIM_ID_LSB +: CLAIM_ID_W]    = 6'(claim_id_r) + 6'd1;
    end else begin
      claim_word_s = 32'h0;
    end
  end

  // Claim/busy next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (claim_s) state_nxt_s = ST_BUSY;
        else         state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (complete_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Claim/busy state and the claimed source ID
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      claim_id_r <= {IDW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (claim_s) claim_id_r <= win_id_s;
    end
  end

  // Source history, pending and configuration registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      src_prev_r <= {NUM_SRC{1'b0}};
      pending_r  <= {NUM_SRC{1'b0}};
      enable_r   <= {NUM_SRC{1'b0}};
      trigger_r  <= {NUM_SRC{1'b0}};
    end else begin
      src_prev_r <= src_s;
      pending_r  <= pending_nxt_s;
      if (wr_en_s)   enable_r  <= (enable_r & ~wmask_s[NUM_SRC-1:0]) | wdata_m_s[NUM_SRC-1:0];
      if (wr_trig_s) trigger_r <= (trigger_r & ~wmask_s[NUM_SRC-1:0]) | wdata_m_s[NUM_SRC-1:0];
    end
  end

  // Registered interrupt line and Wishbone response
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meip_r   <= 1'b0;
      wb_ack_r <= 1'b0;
      wb_dat_r <= 32'h0;
    end else begin
      meip_r   <= (|pend_en_s) & (state_r == ST_IDLE);
      wb_ack_r <= access_s;
      wb_dat_r <= access_s ? rdata_s : 32'h0;
    end
  end

  assign meip_o   = meip_r;
  assign wb_ack_o = wb_ack_r;
  assign wb_dat_o = wb_dat_r;

endmodule

// File: tb/tb_irq_ctrl_wb.sv
// Directed self-checking bench for irq_ctrl_wb (default build, no synchroniser).
`timescale 1ns/1ps
module tb_irq_ctrl_wb;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] irq_src_i = 16'h0;
  logic        meip_o;
  logic        irq_ack_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = 5'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  irq_ctrl_wb dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .irq_src_i (irq_src_i),
    .meip_o    (meip_o),
    .irq_ack_i (irq_ack_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int waits);
    logic got;
    got = 1'b0;
    rd = 32'hDEAD_BEEF;
    waits = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    for (int k = 0; k < 8; k++) begin
      if (!got) begin
        step(1);
        waits++;
        if (wb_ack_o === 1'b1) begin
          got = 1'b1;
          rd = wb_dat_o;
        end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      vec_cnt++;
      err_cnt++;
      $error("FAIL wb_timeout: observed no ack expected ack within 8 clks (adr 0x%02h)", adr);
    end
    step(1);
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    int w;
    wb_xfer(1'b1, adr, dat, 4'hF, rd, w);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    int w;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, w);
    check(tag, rd, exp);
  endtask

  task automatic ack_pulse();
    irq_ack_i = 1'b1;
    step(1);
    irq_ack_i = 1'b0;
    step(1);
  endtask

  task automatic pulse_src(input logic [15:0] mask);
    irq_src_i = mask;
    step(1);
    irq_src_i = 16'h0;
    step(1);
  endtask

  logic [31:0] rdv;
  int          wcnt;

  initial begin
    // Power-on reset
    step(2);
    check("rst_meip", 32'(meip_o), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'h0);
    reset_i = 1'b0;
    step(1);
    rd_chk("rst_pending", 5'h00, 32'h0);

    // 1: reset in the middle of a claim with everything pending
    wr(5'h08, 32'h0000_FFFF);
    wr(5'h04, 32'h0000_FFFF);
    pulse_src(16'hFFFF);
    check("t1_meip_up", 32'(meip_o), 32'd1);
    ack_pulse();
    pulse_src(16'hFFFF);
    rd_chk("t1_pending_full", 5'h00, 32'h0000_FFFF);
    rd_chk("t1_claim_busy", 5'h0C, 32'h8000_0001);
    reset_i = 1'b1;
    step(1);
    check("t1_meip", 32'(meip_o), 32'd0);
    check("t1_ack", 32'(wb_ack_o), 32'd0);
    check("t1_dat", wb_dat_o, 32'h0);
    reset_i = 1'b0;
    step(1);
    rd_chk("t1_pending", 5'h00, 32'h0);
    rd_chk("t1_enable", 5'h04, 32'h0);
    rd_chk("t1_trigger", 5'h08, 32'h0);
    rd_chk("t1_claim", 5'h0C, 32'h0);

    // 2: single edge source, latency and claim
    wr(5'h04, 32'h0000_0005);
    wr(5'h08, 32'h0000_0005);
    irq_src_i = 16'h0004;
    step(1);
    check("t2_meip_1clk", 32'(meip_o), 32'd0);
    irq_src_i = 16'h0000;
    step(1);
    check("t2_meip_2clk", 32'(meip_o), 32'd1);
    rd_chk("t2_pending", 5'h00, 32'h0000_0004);
    ack_pulse();
    check("t2_meip_busy", 32'(meip_o), 32'd0);
    rd_chk("t2_claim", 5'h0C, 32'h8000_0003);
    rd_chk("t2_pending_clr", 5'h00, 32'h0);
    wr(5'h10, 32'h0);

    // 3: two pending sources, lowest index wins first
    pulse_src(16'h0005);
    check("t3_meip", 32'(meip_o), 32'd1);
    ack_pulse();
    check("t3_meip_busy", 32'(meip_o), 32'd0);
    rd_chk("t3_claim0", 5'h0C, 32'h8000_0001);
    rd_chk("t3_pending", 5'h00, 32'h0000_0004);
    wr(5'h10, 32'h0);
    check("t3_meip_again", 32'(meip_o), 32'd1);
    ack_pulse();
    rd_chk("t3_claim2", 5'h0C, 32'h8000_0003);
    wr(5'h10, 32'h0);

    // 4: level source held high across a claim
    wr(5'h04, 32'h0000_0007);
    irq_src_i = 16'h0002;
    step(2);
    check("t4_meip", 32'(meip_o), 32'd1);
    ack_pulse();
    check("t4_meip_busy", 32'(meip_o), 32'd0);
    rd_chk("t4_claim", 5'h0C, 32'h8000_0002);
    rd_chk("t4_pending", 5'h00, 32'h0000_0002);
    wr(5'h00, 32'h0000_0002);
    rd_chk("t4_level_w1c", 5'h00, 32'h0000_0002);
    wr(5'h10, 32'h0);
    check("t4_meip_back", 32'(meip_o), 32'd1);
    irq_src_i = 16'h0000;
    step(2);
    check("t4_meip_drop", 32'(meip_o), 32'd0);

    // 5: spurious ack, then edge set racing a W1C
    ack_pulse();
    check("t5_meip", 32'(meip_o), 32'd0);
    rd_chk("t5_claim", 5'h0C, 32'h0);
    irq_src_i = 16'h0001;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 5'h00; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    step(1);
    check("t5_w1c_ack", 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    irq_src_i = 16'h0000;
    step(1);
    rd_chk("t5_set_wins", 5'h00, 32'h0000_0001);
    wr(5'h00, 32'h0000_0001);
    rd_chk("t5_w1c", 5'h00, 32'h0);

    // 6: unmapped offset and byte-select writes
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, rdv, wcnt);
    check("t6_unmapped_rd", rdv, 32'h0);
    check("t6_wait_states", 32'(wcnt), 32'd1);
    check("t6_ack_drop", 32'(wb_ack_o), 32'd0);
    wr(5'h14, 32'hFFFF_FFFF);
    rd_chk("t6_enable_kept", 5'h04, 32'h0000_0007);
    rd_chk("t6_trigger_kept", 5'h08, 32'h0000_0005);
    wr(5'h04, 32'h0000_1234);
    wb_xfer(1'b1, 5'h04, 32'hFFFF_FFFF, 4'b0001, rdv, wcnt);
    rd_chk("t6_sel_byte0", 5'h04, 32'h0000_12FF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
